// File: rtl/pixel_readout_pkg.sv
// Shared types and default geometry for the pixel readout path.
// The PIXEL_COUNT/DATA_W defaults must match the sensor controller's read length.
package pixel_readout_pkg;

    localparam int PIXEL_COUNT_DEF = 4;
    localparam int DATA_W_DEF      = 8;
    localparam int DROP_W_DEF      = 8;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM
    } drain_state_t;

endpackage

// File: rtl/pixel_bank_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
// The bank select is the address MSB, so both frame banks share one array.
module pixel_bank_ram #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // NOTE: the storage array has no reset so it maps onto block RAM; bank
    // state alone decides whether its contents are meaningful.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pixel_readout.sv
// Double-buffered capture of ADC pixel words with a valid/ready frame stream out.
// Optional black-level clamp: define PIXEL_READOUT_BLACK_CLAMP_EN.
import pixel_readout_pkg::*;

module pixel_readout #(
    parameter int PIXEL_COUNT = PIXEL_COUNT_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SEL_W       = $clog2(PIXEL_COUNT),
    parameter int DROP_W      = DROP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic [SEL_W-1:0]  pixel_select,
    input  logic [DATA_W-1:0] pixel_data,
`ifdef PIXEL_READOUT_BLACK_CLAMP_EN
    input  logic [DATA_W-1:0] black_level,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic [DROP_W-1:0] drop_count
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(PIXEL_COUNT - 1);

    bank_state_t       r_bank_state [2];
    bank_state_t       w_bank_next  [2];
    drain_state_t      r_drain_state;
    drain_state_t      w_drain_next;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic              r_read_q;
    logic              r_frame_end_q;
    logic              r_ignore;
    logic [SEL_W-1:0]  r_rd_idx;
    logic [SEL_W-1:0]  w_rd_idx_next;
    logic [DROP_W-1:0] r_drop_count;

    logic              w_burst_start;
    logic              w_wr_bank_free;
    logic              w_capture;
    logic              w_commit;
    logic              w_abort;
    logic              w_drop_burst;
    logic              w_last_xfer;
    logic              w_ram_rd_en;
    logic [SEL_W:0]    w_ram_rd_addr;
    logic [DATA_W-1:0] w_ram_q;

    // A new frame begins on a read rising edge or straight after a frame's last pixel.
    assign w_burst_start  = read && (!r_read_q || r_frame_end_q);
    assign w_wr_bank_free = (r_bank_state[r_wr_ptr] == EMPTY) ||
                            (w_last_xfer && (r_rd_ptr == r_wr_ptr));
    assign w_capture      = read && (w_burst_start ? w_wr_bank_free : !r_ignore);
    assign w_drop_burst   = w_burst_start && !w_wr_bank_free;
    assign w_commit       = w_capture && (pixel_select == LAST_SEL);
    assign w_abort        = !read && (r_bank_state[r_wr_ptr] == FILLING);

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and infers a latch.
    always_comb begin
        w_drain_next  = r_drain_state;
        w_rd_idx_next = r_rd_idx;
        w_ram_rd_en   = 1'b0;
        w_ram_rd_addr = {r_rd_ptr, r_rd_idx};
        w_last_xfer   = 1'b0;
        case (r_drain_state)
            IDLE: begin
                if (r_bank_state[r_rd_ptr] == FULL) begin
                    w_drain_next = FETCH;
                end
            end
            FETCH: begin
                w_ram_rd_en   = 1'b1;
                w_rd_idx_next = '0;
                w_ram_rd_addr = {r_rd_ptr, {SEL_W{1'b0}}};
                w_drain_next  = STREAM;
            end
            STREAM: begin
                if (out_ready) begin
                    if (r_rd_idx == LAST_SEL) begin
                        w_last_xfer  = 1'b1;
                        w_drain_next = (r_bank_state[~r_rd_ptr] == FULL) ? FETCH : IDLE;
                    end else begin
                        // Prefetch the next pixel on the transfer edge: no bubbles.
                        w_ram_rd_en   = 1'b1;
                        w_rd_idx_next = r_rd_idx + SEL_W'(1);
                        w_ram_rd_addr = {r_rd_ptr, w_rd_idx_next};
                    end
                end
            end
            default: w_drain_next = IDLE;
        endcase
    end

    // Write-side updates come last so a capture wins over a same-edge free.
    always_comb begin
        w_bank_next = r_bank_state;
        if (r_drain_state == FETCH) begin
            w_bank_next[r_rd_ptr] = DRAINING;
        end
        if (w_last_xfer) begin
            w_bank_next[r_rd_ptr] = EMPTY;
        end
        if (w_abort) begin
            w_bank_next[r_wr_ptr] = EMPTY;
        end
        if (w_capture) begin
            w_bank_next[r_wr_ptr] = w_commit ? FULL : FILLING;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bank_state  <= '{EMPTY, EMPTY};
            r_drain_state <= IDLE;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_read_q      <= 1'b0;
            r_frame_end_q <= 1'b0;
            r_ignore      <= 1'b0;
            r_rd_idx      <= '0;
            r_drop_count  <= '0;
        end else begin
            r_bank_state  <= w_bank_next;
            r_drain_state <= w_drain_next;
            r_rd_idx      <= w_rd_idx_next;
            r_read_q      <= read;
            r_frame_end_q <= read && (pixel_select == LAST_SEL);
            if (!read) begin
                r_ignore <= 1'b0;
            end else if (w_burst_start) begin
                r_ignore <= !w_wr_bank_free;
            end
            if (w_commit) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_last_xfer) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if ((w_drop_burst || w_abort) && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + DROP_W'(1);
            end
        end
    end

    pixel_bank_ram #(
        .ADDR_W (SEL_W + 1),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_capture),
        .i_wr_addr ({r_wr_ptr, pixel_select}),
        .i_wr_data (pixel_data),
        .i_rd_en   (w_ram_rd_en),
        .i_rd_addr (w_ram_rd_addr),
        .o_rd_data (w_ram_q)
    );

`ifdef PIXEL_READOUT_BLACK_CLAMP_EN
    logic [DATA_W-1:0] r_black [2];

    // Black level is latched per bank at commit and applied on the RAM output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_black <= '{'0, '0};
        end else if (w_commit) begin
            r_black[r_wr_ptr] <= black_level;
        end
    end

    assign out_data = (w_ram_q > r_black[r_rd_ptr]) ? (w_ram_q - r_black[r_rd_ptr]) : '0;
`else
    assign out_data = w_ram_q;
`endif

    assign out_valid  = (r_drain_state == STREAM);
    assign out_last   = out_valid && (r_rd_idx == LAST_SEL);
    assign busy       = (r_bank_state[0] != EMPTY) || (r_bank_state[1] != EMPTY) ||
                        (r_drain_state != IDLE);
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_pixel_readout.sv
// Self-checking bench for pixel_readout: vector table, corner-case sequences,
// and a randomized run scored against a frame-level reference model.
module tb_pixel_readout;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       read = 1'b0;
    logic [1:0] pixel_select = '0;
    logic [7:0] pixel_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic [7:0] drop_count;
`ifdef PIXEL_READOUT_BLACK_CLAMP_EN
    logic [7:0] black_level = '0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pixel_readout dut (
        .clk          (clk),
        .reset        (reset),
        .read         (read),
        .pixel_select (pixel_select),
        .pixel_data   (pixel_data),
`ifdef PIXEL_READOUT_BLACK_CLAMP_EN
        .black_level  (black_level),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .drop_count   (drop_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transfer monitor and reference model ----------------
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    bit         model_en   = 1'b0;
    bit         rand_mode  = 1'b0;
    bit         prev_stall = 1'b0;
    logic [8:0] prev_word;
    logic [7:0] m_buf [4];
    bit         m_in_burst;
    bit         m_accepted;
    int         m_occ;
    int         m_drops;

    task automatic model_clear();
        m_in_burst = 1'b0;
        m_accepted = 1'b0;
        m_occ      = 0;
        m_drops    = 0;
        exp_q.delete();
    endtask

    function automatic logic [7:0] clamp_sub(input logic [7:0] pix, input logic [7:0] bl);
        return (pix > bl) ? pix - bl : 8'h00;
    endfunction

    // Inputs change at posedge+1, so at the negedge they show what the next edge samples.
    always @(negedge clk) begin
        if (reset) begin
            if (prev_stall) begin
                check("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_word});
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, out_data});
                if (model_en) begin
                    check("rand_extra_word", (exp_q.size() > 0) ? 1 : 0, 1);
                    if (exp_q.size() > 0) begin
                        logic [8:0] w;
                        w = exp_q.pop_front();
                        check("rand_word", {out_last, out_data}, w);
                        if (w[8]) m_occ--;
                    end
                end
            end
            if (model_en) begin
                if (read) begin
                    if (!m_in_burst) begin
                        m_in_burst = 1'b1;
                        if (m_occ >= 2) begin
                            m_accepted = 1'b0;
                            if (m_drops < 255) m_drops++;
                        end else begin
                            m_accepted = 1'b1;
                            m_occ++;
                        end
                    end
                    if (m_accepted) m_buf[pixel_select] = pixel_data;
                    if (pixel_select == 2'd3) begin
                        if (m_accepted) begin
                            logic [7:0] bl;
                            bl = 8'h00;
`ifdef PIXEL_READOUT_BLACK_CLAMP_EN
                            bl = black_level;
`endif
                            for (int i = 0; i < 4; i++) begin
                                exp_q.push_back({(i == 3), clamp_sub(m_buf[i], bl)});
                            end
                        end
                        m_in_burst = 1'b0;
                        m_accepted = 1'b0;
                    end
                end else begin
                    if (m_in_burst && m_accepted) begin
                        m_occ--;
                        if (m_drops < 255) m_drops++;
                    end
                    m_in_burst = 1'b0;
                    m_accepted = 1'b0;
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic rd, input logic [1:0] sel, input logic [7:0] dat);
        read         = rd;
        pixel_select = sel;
        pixel_data   = dat;
        if (rand_mode) begin
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef PIXEL_READOUT_BLACK_CLAMP_EN
            black_level = 8'($urandom_range(0, 63));
`endif
        end
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        read  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d0, d1, d2, d3);
        drive(1'b1, 2'd0, d0);
        drive(1'b1, 2'd1, d1);
        drive(1'b1, 2'd2, d2);
        drive(1'b1, 2'd3, d3);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        check(name, out_valid, 1'b1);
    endtask

    task automatic wait_words(input int count, input int budget);
        int n;
        n = 0;
        while (got_q.size() < count && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic check_words(input string name, input logic [7:0] words [8], input int count);
        check({name, "_count"}, got_q.size(), count);
        for (int i = 0; i < count && i < got_q.size(); i++) begin
            check(name, got_q[i], {((i % 4) == 3), words[i]});
        end
    endtask

    typedef struct {
        logic       rd;
        logic [1:0] sel;
        logic [7:0] data;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_last;
        logic       e_busy;
    } vec_t;

    vec_t       vecs [11];
    logic [7:0] words [8];
    int         vtrace [$];

    initial begin
        // read, sel, data | valid, data, last, busy (after the edge that samples the row)
        vecs[0]  = '{1'b1, 2'd0, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 2'd1, 8'h20, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 2'd2, 8'h30, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 2'd3, 8'h40, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 2'd0, 8'h00, 1'b1, 8'h10, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 2'd0, 8'h00, 1'b1, 8'h20, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 2'd0, 8'h00, 1'b1, 8'h30, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 2'd0, 8'h00, 1'b1, 8'h40, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

        // Reset state
        reset = 1'b0;
        tick();
        tick();
        check("rst_valid", out_valid, 1'b0);
        check("rst_last", out_last, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_drop", drop_count, 8'h00);
        reset = 1'b1;

        // Single frame, ready held high: latency, order, last flag
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rd, vecs[i].sel, vecs[i].data);
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
            check($sformatf("vec%0d_last", i), out_last, vecs[i].e_last);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            if (vecs[i].e_valid) check($sformatf("vec%0d_data", i), out_data, vecs[i].e_data);
        end

        // Backpressure
        do_reset();
        got_q.delete();
        out_ready = 1'b0;
        send_frame(8'h10, 8'h20, 8'h30, 8'h40);
        drive(1'b0, 2'd0, 8'h00);
        wait_valid("bp_valid", 10);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_stall_data", {out_valid, out_data}, {1'b1, 8'h10});
        end
        for (int i = 0; i < 40 && got_q.size() < 4; i++) begin
            out_ready = (i % 2 == 0);
            tick();
        end
        out_ready = 1'b0;
        tick();
        tick();
        words = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
        check_words("bp_word", words, 4);
        check("bp_busy_end", busy, 1'b0);

        // Continuous mode: back-to-back frames, one-cycle gap between them
        do_reset();
        got_q.delete();
        vtrace.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'(i % 4), (i < 4) ? 8'(8'hA1 + i) : 8'(8'hB1 + i - 4));
            vtrace.push_back(int'(out_valid));
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 2'd0, 8'h00);
            vtrace.push_back(int'(out_valid));
        end
        begin
            int first_hi;
            int last_hi;
            int gaps;
            first_hi = -1;
            last_hi  = -1;
            gaps     = 0;
            foreach (vtrace[k]) begin
                if (vtrace[k] != 0) begin
                    if (first_hi < 0) first_hi = k;
                    last_hi = k;
                end
            end
            for (int k = first_hi + 1; k < last_hi; k++) if (vtrace[k] == 0) gaps++;
            check("cont_gap", gaps, 1);
        end
        words = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        check_words("cont_word", words, 8);
        check("cont_drop", drop_count, 8'h00);

        // Overflow: third frame dropped while both banks occupied
        do_reset();
        got_q.delete();
        out_ready = 1'b0;
        send_frame(8'h11, 8'h12, 8'h13, 8'h14);
        drive(1'b0, 2'd0, 8'h00);
        send_frame(8'h21, 8'h22, 8'h23, 8'h24);
        drive(1'b0, 2'd0, 8'h00);
        send_frame(8'h31, 8'h32, 8'h33, 8'h34);
        drive(1'b0, 2'd0, 8'h00);
        check("ovf_drop", drop_count, 8'h01);
        check("ovf_busy", busy, 1'b1);
        out_ready = 1'b1;
        wait_words(8, 40);
        tick();
        tick();
        tick();
        words = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h21, 8'h22, 8'h23, 8'h24};
        check_words("ovf_word", words, 8);
        check("ovf_busy_end", busy, 1'b0);

        // Abort: read falls after pixel 1
        do_reset();
        got_q.delete();
        out_ready = 1'b1;
        drive(1'b1, 2'd0, 8'h55);
        drive(1'b1, 2'd1, 8'h66);
        drive(1'b0, 2'd0, 8'h00);
        check("abort_drop", drop_count, 8'h01);
        begin
            int seen_valid;
            seen_valid = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (out_valid) seen_valid++;
            end
            check("abort_no_output", seen_valid, 0);
        end
        check("abort_busy", busy, 1'b0);

        // Reset mid-drain (drop_count is still 1 from the abort)
        out_ready = 1'b0;
        send_frame(8'h71, 8'h72, 8'h73, 8'h74);
        drive(1'b0, 2'd0, 8'h00);
        wait_valid("mid_valid", 10);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_drop", drop_count, 8'h00);
        check("mid_rst_out", {out_last, out_data}, 9'h000);
        tick();
        tick();
        tick();
        check("mid_rst_discard", {out_valid, busy}, 2'b00);

`ifdef PIXEL_READOUT_BLACK_CLAMP_EN
        // Black-level clamp
        do_reset();
        got_q.delete();
        out_ready   = 1'b1;
        black_level = 8'h18;
        send_frame(8'h10, 8'h20, 8'hFF, 8'h18);
        black_level = 8'h00;
        drive(1'b0, 2'd0, 8'h00);
        wait_words(4, 20);
        words = '{8'h00, 8'h08, 8'hE7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_words("clamp_word", words, 4);
`endif

        // Randomized traffic against the frame-level model
        do_reset();
        got_q.delete();
        model_clear();
        model_en  = 1'b1;
        rand_mode = 1'b1;
        for (int f = 0; f < 200; f++) begin
            if ($urandom_range(0, 9) == 0) begin
                int len;
                len = $urandom_range(1, 3);
                for (int p = 0; p < len; p++) drive(1'b1, 2'($urandom_range(0, 2)), 8'($urandom));
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) drive(1'b0, 2'($urandom), 8'($urandom));
            end else begin
                int order [3];
                order = '{0, 1, 2};
                for (int i = 2; i > 0; i--) begin
                    int j;
                    int t;
                    j = $urandom_range(0, i);
                    t = order[i];
                    order[i] = order[j];
                    order[j] = t;
                end
                for (int p = 0; p < 3; p++) drive(1'b1, 2'(order[p]), 8'($urandom));
                drive(1'b1, 2'd3, 8'($urandom));
                for (int g = 0; g < int'($urandom_range(0, 3)); g++) drive(1'b0, 2'($urandom), 8'($urandom));
            end
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        read      = 1'b0;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
        tick();
        tick();
        check("rand_drain_empty", exp_q.size(), 0);
        check("rand_drops", drop_count, 8'(m_drops));
        check("rand_busy_end", busy, 1'b0);
        model_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
